// File: rtl/audio_out_fifo_scheduler_pkg.sv
// rtl/audio_out_fifo_scheduler_pkg.sv - shared state encoding and counter helpers for the audio output scheduler
package audio_out_fifo_scheduler_pkg;

    localparam int UNDERFLOW_WIDTH = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] POP   = 2'd1;
    localparam logic [1:0] UNDER = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // An UNDER cycle and a dropped request can land together, so up to 2 per clock.
    function automatic logic [UNDERFLOW_WIDTH-1:0] sat_add(
        input logic [UNDERFLOW_WIDTH-1:0] value,
        input logic [1:0]                 inc
    );
        logic [UNDERFLOW_WIDTH:0] sum;
        sum = {1'b0, value} + {{(UNDERFLOW_WIDTH-1){1'b0}}, inc};
        return sum[UNDERFLOW_WIDTH] ? {UNDERFLOW_WIDTH{1'b1}} : sum[UNDERFLOW_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/audio_out_fifo_scheduler_fifo_free_space.sv
// rtl/audio_out_fifo_scheduler_fifo_free_space.sv - free-word count of one channel FIFO
module fifo_free_space #(
    parameter int DATA_DEPTH = 128,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  full,
    input  logic [ADDR_WIDTH-1:0] words_used,
    output logic [ADDR_WIDTH:0]   free_words
);

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(DATA_DEPTH);

    // words_used wraps to 0 when the FIFO is full, so full must override the subtraction.
    assign free_words = full ? '0 : DEPTH - {1'b0, words_used};

endmodule

// File: rtl/audio_out_fifo_scheduler.sv
// rtl/audio_out_fifo_scheduler.sv - pops both channel FIFOs in lockstep per serializer request
module audio_out_fifo_scheduler
    import audio_out_fifo_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DATA_DEPTH    = 128,
    parameter int ADDR_WIDTH    = 7,
    parameter int IRQ_THRESHOLD = 96
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       sample_req,
    input  logic                       left_empty,
    input  logic                       right_empty,
    input  logic                       left_full,
    input  logic                       right_full,
    input  logic [ADDR_WIDTH-1:0]      left_words_used,
    input  logic [ADDR_WIDTH-1:0]      right_words_used,
    input  logic [DATA_WIDTH-1:0]      left_read_data,
    input  logic [DATA_WIDTH-1:0]      right_read_data,
    input  logic                       clear_underflow,
    output logic                       left_read_en,
    output logic                       right_read_en,
    output logic [DATA_WIDTH-1:0]      left_sample,
    output logic [DATA_WIDTH-1:0]      right_sample,
    output logic                       sample_valid,
    output logic [UNDERFLOW_WIDTH-1:0] underflow_count,
    output logic                       space_irq
);

    localparam logic [ADDR_WIDTH:0] IRQ_LEVEL = (ADDR_WIDTH+1)'(IRQ_THRESHOLD);

    logic [1:0]                 state;
    logic                       pending;
    logic [UNDERFLOW_WIDTH-1:0] uf_count;
    logic [ADDR_WIDTH:0]        left_free;
    logic [ADDR_WIDTH:0]        right_free;
    logic                       drop;
    logic                       under_inc;

    fifo_free_space #(.DATA_DEPTH(DATA_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_left_free (
        .full       (left_full),
        .words_used (left_words_used),
        .free_words (left_free)
    );

    fifo_free_space #(.DATA_DEPTH(DATA_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_right_free (
        .full       (right_full),
        .words_used (right_words_used),
        .free_words (right_free)
    );

    always_comb begin
        drop      = sample_req && (state != IDLE) && pending;
        under_inc = (state == UNDER) && enable;
    end

    // One shared strobe drives both pops so the channels can never drift apart.
    assign left_read_en    = (state == POP) && !reset;
    assign right_read_en   = (state == POP) && !reset;
    assign sample_valid    = (state == DONE);
    assign underflow_count = uf_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pending      <= 1'b0;
            left_sample  <= '0;
            right_sample <= '0;
            uf_count     <= '0;
            space_irq    <= 1'b0;
        end else begin
            space_irq <= enable && (left_free >= IRQ_LEVEL) && (right_free >= IRQ_LEVEL);
            uf_count  <= clear_underflow ? '0
                                         : sat_add(uf_count, {1'b0, under_inc} + {1'b0, drop});
            case (state)
                IDLE: begin
                    // A fresh request arriving while a pending one is consumed stays queued.
                    pending <= pending && sample_req;
                    if (sample_req || pending) begin
                        state <= (enable && !left_empty && !right_empty) ? POP : UNDER;
                    end
                end
                POP: begin
                    pending      <= pending || sample_req;
                    left_sample  <= left_read_data;
                    right_sample <= right_read_data;
                    state        <= DONE;
                end
                UNDER: begin
                    pending      <= pending || sample_req;
                    left_sample  <= '0;
                    right_sample <= '0;
                    state        <= DONE;
                end
                default: begin
                    pending <= pending || sample_req;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_out_fifo_scheduler.sv
// tb/tb_audio_out_fifo_scheduler.sv - scoreboard bench with FIFO models and a request-timing reference model
module tb_audio_out_fifo_scheduler;

    localparam int DW    = 32;
    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int THR   = 96;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          sample_req = 1'b0;
    logic          left_empty = 1'b1;
    logic          right_empty = 1'b1;
    logic          left_full = 1'b0;
    logic          right_full = 1'b0;
    logic [AW-1:0] left_words_used = '0;
    logic [AW-1:0] right_words_used = '0;
    logic [DW-1:0] left_read_data = '0;
    logic [DW-1:0] right_read_data = '0;
    logic          clear_underflow = 1'b0;
    logic          left_read_en;
    logic          right_read_en;
    logic [DW-1:0] left_sample;
    logic [DW-1:0] right_sample;
    logic          sample_valid;
    logic [15:0]   underflow_count;
    logic          space_irq;

    audio_out_fifo_scheduler #(
        .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .ADDR_WIDTH(AW), .IRQ_THRESHOLD(THR)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .sample_req       (sample_req),
        .left_empty       (left_empty),
        .right_empty      (right_empty),
        .left_full        (left_full),
        .right_full       (right_full),
        .left_words_used  (left_words_used),
        .right_words_used (right_words_used),
        .left_read_data   (left_read_data),
        .right_read_data  (right_read_data),
        .clear_underflow  (clear_underflow),
        .left_read_en     (left_read_en),
        .right_read_en    (right_read_en),
        .left_sample      (left_sample),
        .right_sample     (right_sample),
        .sample_valid     (sample_valid),
        .underflow_count  (underflow_count),
        .space_irq        (space_irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } exp_t;

    logic [DW-1:0] ql[$];
    logic [DW-1:0] qr[$];
    exp_t          sb[$];
    int            starts[$];
    bit            exp_pop[int];
    bit            exp_valid[int];
    bit            clr_at[int];
    bit            irq_exp[int];
    int            uf_add[int];
    int            uf_set[int];
    int            exp_uf = 0;
    int            next_free = 0;
    int            last_start = -1;
    int            under_at = -1;
    bit            pop_l = 0;
    bit            pop_r = 0;

    bit req_i = 0;
    bit en_i = 0;
    bit clr_i = 0;
    int wr_l = 0;
    int wr_r = 0;

    function automatic int free_of(input int size);
        return (size == DEPTH) ? 0 : DEPTH - size;
    endfunction

    task automatic add_uf(input int k);
        if (uf_add.exists(k)) uf_add[k] = uf_add[k] + 1;
        else uf_add[k] = 1;
    endtask

    task automatic model_reset();
        sb.delete(); starts.delete(); exp_pop.delete(); exp_valid.delete();
        clr_at.delete(); irq_exp.delete(); uf_add.delete(); uf_set.delete();
        exp_uf = 0; next_free = 0; last_start = -1; under_at = -1;
        pop_l = 0; pop_r = 0;
    endtask

    // One clock of environment: FIFO models, stimulus drive and expectation scheduling.
    task automatic step();
        int k;
        @(negedge clk);
        k = cyc;
        if (reset) reset = 1'b0;
        if (pop_l && ql.size() > 0) ql.delete(0);
        if (pop_r && qr.size() > 0) qr.delete(0);
        for (int i = 0; i < wr_l; i++) if (ql.size() < DEPTH) ql.push_back($urandom);
        for (int i = 0; i < wr_r; i++) if (qr.size() < DEPTH) qr.push_back($urandom);
        left_empty       = (ql.size() == 0);
        right_empty      = (qr.size() == 0);
        left_full        = (ql.size() == DEPTH);
        right_full       = (qr.size() == DEPTH);
        left_words_used  = AW'(ql.size());
        right_words_used = AW'(qr.size());
        left_read_data   = (ql.size() > 0) ? ql[0] : '0;
        right_read_data  = (qr.size() > 0) ? qr[0] : '0;
        enable           = en_i;
        sample_req       = req_i;
        clear_underflow  = clr_i;

        if (under_at == k) begin
            if (en_i) add_uf(k + 1);
            under_at = -1;
        end
        // Each service occupies three cycles; one request may wait, a further one is lost.
        if (req_i) begin
            if (k >= next_free) begin
                starts.push_back(k); last_start = k; next_free = k + 3;
            end else if (last_start > k) begin
                add_uf(k + 1);
            end else begin
                starts.push_back(next_free); last_start = next_free; next_free = next_free + 3;
            end
        end
        if (starts.size() > 0 && starts[0] == k) begin
            starts.delete(0);
            exp_valid[k + 2] = 1;
            if (en_i && ql.size() > 0 && qr.size() > 0) begin
                exp_pop[k + 1] = 1;
                sb.push_back('{l: ql[0], r: qr[0]});
            end else begin
                sb.push_back('{l: '0, r: '0});
                under_at = k + 1;
            end
        end
        irq_exp[k + 1] = en_i && (free_of(ql.size()) >= THR) && (free_of(qr.size()) >= THR);
        if (clr_i) clr_at[k + 1] = 1;
        pop_l = left_read_en;
        pop_r = right_read_en;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    always @(negedge clk) begin
        int   k;
        exp_t e;
        k = cyc;
        if (!reset) begin
            if (uf_set.exists(k)) exp_uf = uf_set[k];
            if (clr_at.exists(k)) exp_uf = 0;
            else if (uf_add.exists(k)) exp_uf = (exp_uf + uf_add[k] > 65535) ? 65535 : exp_uf + uf_add[k];
            check("underflow_count", underflow_count, exp_uf);
            check("left_read_en", left_read_en, exp_pop.exists(k));
            check("right_read_en", right_read_en, exp_pop.exists(k));
            check("space_irq", space_irq, irq_exp.exists(k) ? irq_exp[k] : 1'b0);
            check("sample_valid", sample_valid, exp_valid.exists(k));
            if (sample_valid) begin
                check("scoreboard_entry", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("left_sample", left_sample, e.l);
                    check("right_sample", right_sample, e.r);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_left_read_en", left_read_en, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_left_sample", left_sample, 0);
        check("rst_underflow_count", underflow_count, 0);
        check("rst_space_irq", space_irq, 0);
        step();
        en_i = 1;
        idle(3);

        // both FIFOs hold 4 words: normal pop
        wr_l = 4; wr_r = 4; step(); wr_l = 0; wr_r = 0;
        idle(2); req_i = 1; step(); req_i = 0; idle(4);

        // left empty, right holds 3: underflow, no pop
        ql.delete(); qr.delete();
        wr_r = 3; step(); wr_r = 0;
        req_i = 1; step(); req_i = 0; idle(4);

        // three back-to-back requests: serviced, pending, dropped
        wr_l = 8; wr_r = 8; step(); wr_l = 0; wr_r = 0;
        req_i = 1; idle(3); req_i = 0; idle(8);

        // free-space interrupt: full with wrapped count, then both at 32 used
        ql.delete(); qr.delete();
        for (int i = 0; i < DEPTH; i++) ql.push_back($urandom);
        for (int i = 0; i < DEPTH - 10; i++) qr.push_back($urandom);
        idle(3);
        ql.delete(); qr.delete();
        for (int i = 0; i < 32; i++) begin ql.push_back($urandom); qr.push_back($urandom); end
        idle(3);

        // saturation and clear priority
        ql.delete(); qr.delete();
        idle(2);
        #1 force dut.uf_count = 16'hFFFE;
        #1 release dut.uf_count;
        uf_set[cyc + 1] = 16'hFFFE;
        req_i = 1; step(); req_i = 0; idle(4);
        req_i = 1; step(); req_i = 0; idle(4);
        check("saturated_count", underflow_count, 16'hFFFF);
        req_i = 1; step(); req_i = 0; clr_i = 1; step(); clr_i = 0; idle(4);

        // reset during POP
        wr_l = 4; wr_r = 4; step(); wr_l = 0; wr_r = 0;
        req_i = 1; step(); req_i = 0; step();
        check("pop_before_reset", left_read_en, 1);
        #1 reset = 1'b1;
        model_reset();
        #1;
        check("rst_pop_left_read_en", left_read_en, 0);
        check("rst_pop_right_read_en", right_read_en, 0);
        check("rst_pop_sample_valid", sample_valid, 0);
        check("rst_pop_right_sample", right_sample, 0);
        check("rst_pop_underflow_count", underflow_count, 0);
        step();
        idle(2);
        req_i = 1; step(); req_i = 0; idle(4);
        check("fifo_kept_after_reset", ql.size(), 3);

        // randomized traffic
        for (int b = 0; b < 6; b++) begin
            int rate;
            rate = $urandom_range(5, 60);
            for (int i = 0; i < 500; i++) begin
                req_i = ($urandom_range(0, 99) < 40);
                en_i  = ($urandom_range(0, 99) < 92);
                clr_i = ($urandom_range(0, 199) == 0);
                wr_l  = ($urandom_range(0, 99) < rate) ? $urandom_range(1, 2) : 0;
                wr_r  = ($urandom_range(0, 99) < rate) ? $urandom_range(1, 2) : 0;
                step();
            end
        end
        req_i = 0; clr_i = 0; wr_l = 0; wr_r = 0; en_i = 1;
        idle(8);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_out_fifo_scheduler.md
AUDIO_OUT_FIFO_SCHEDULER -- requirements
Module: audio_out_fifo_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, sample width per channel.
REQ-002 SHALL have parameter DATA_DEPTH, default 128, words per channel FIFO.
REQ-003 SHALL have parameter ADDR_WIDTH, default 7, width of FIFO used-words count.
REQ-004 SHALL have parameter IRQ_THRESHOLD, default 96, minimum free words on both channels that raises space_irq.
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port enable, input, 1, playback enable.
REQ-008 SHALL have port sample_req, input, 1, one-cycle pulse from the serializer requesting the next stereo sample.
REQ-009 SHALL have ports left_empty/right_empty and left_full/right_full, input, 1 each, channel FIFO flags.
REQ-010 SHALL have ports left_words_used/right_words_used, input, ADDR_WIDTH each, FIFO used-words counts.
REQ-011 SHALL have ports left_read_data/right_read_data, input, DATA_WIDTH each, show-ahead FIFO heads.
REQ-012 SHALL have port clear_underflow, input, 1, pulse that clears underflow_count.
REQ-013 SHALL have ports left_read_en/right_read_en, output, 1 each, FIFO pop strobes.
REQ-014 SHALL have ports left_sample/right_sample, output, DATA_WIDTH each, registered samples to the serializer.
REQ-015 SHALL have port sample_valid, output, 1, one-cycle strobe qualifying the samples.
REQ-016 SHALL have port underflow_count, output, 16, saturating count of missed samples.
REQ-017 SHALL have port space_irq, output, 1, level interrupt for the write-side refill.

Function
REQ-018 SHALL implement FSM states IDLE, POP, UNDER, DONE.
REQ-019 IDLE: on sample_req or pending, go to POP if enable=1 and both empty flags are 0; otherwise go to UNDER; clear pending.
REQ-020 POP, one cycle: assert left_read_en and right_read_en together; load left_sample/right_sample from the read_data inputs; go to DONE.
REQ-021 UNDER, one cycle: load both samples with 0; no read_en; increment underflow_count only if enable=1; go to DONE.
REQ-022 DONE, one cycle: sample_valid=1; go to IDLE.
REQ-023 Latency: sample_req in IDLE at cycle N gives read_en at N+1 and sample_valid at N+2.
REQ-024 Both channels SHALL always pop in lockstep; one channel alone SHALL never be popped, so L/R alignment is preserved.
REQ-025 sample_req outside IDLE SHALL set a one-deep pending flag; a second request while pending is set SHALL be dropped and counted as an underflow.
REQ-026 underflow_count SHALL saturate at 16'hFFFF; clear_underflow coincident with an increment SHALL win, giving 0.
REQ-027 Free words per channel = 0 if full=1, else DATA_DEPTH - words_used, computed at ADDR_WIDTH+1 bits. The full=1 case covers usedw wrapping to 0 when full.
REQ-028 space_irq SHALL be registered, high when both free counts >= IRQ_THRESHOLD, and forced 0 when enable=0.
REQ-029 Deasserting enable mid-sequence SHALL NOT abort POP; the current transaction SHALL complete.

Reset
REQ-030 Reset SHALL force asynchronously: FSM to IDLE; pending, read_en, sample_valid and space_irq to 0; samples to 0; underflow_count to 0.
REQ-031 Reset asserted during POP SHALL suppress read_en immediately; no partial pop survives.

Structure
REQ-032 State encoding and UNDERFLOW_WIDTH=16 SHALL live in the shared audio package.
REQ-033 Free-space calculation SHALL be a sub-module, fifo_free_space, instantiated once per channel.

Verification
REQ-034 Both FIFOs hold 4 words, enable=1, sample_req at cycle 10 -> both read_en at 11, sample_valid at 12 with heads; no underflow.
REQ-035 Left FIFO empty, right holds 3, sample_req -> no read_en, samples 0, underflow_count 0->1, right level unchanged.
REQ-036 sample_req on 3 consecutive cycles -> one serviced, one pending then serviced at cycle+4, one dropped; underflow_count=1.
REQ-037 left_full=1 with words_used=0, right_words_used=10 -> space_irq=0; both words_used=32 -> space_irq=1 one cycle later.
REQ-038 underflow_count=16'hFFFF plus underflow -> holds 16'hFFFF; clear_underflow with simultaneous underflow -> 0.
REQ-039 Reset asserted during POP -> read_en low the same cycle, all outputs 0, FSM IDLE after release.
